calc_key_sequencer: RTL and testbench

- Front-end controller for the calculator arithmetic/BCD datapath.
- Collects keypad key codes and builds two BCD operands with digit counts and an operator code.
- Launches the datapath with a start/done handshake and holds the displayed value: operand being typed, result, or error.
- Sits between the keypad decoder and the arithmetic unit; drives the 3-digit display.

---
 rtl/calc_key_sequencer_if.sv | 26 ++
 rtl/calc_key_sequencer.sv | 158 +++++++++++++++
 tb/tb_calc_key_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/calc_key_sequencer_if.sv
// calc_key_sequencer_if: keypad, datapath and display signals of the calculator sequencer.
// master = keypad/datapath environment side, slave = sequencer side.
interface calc_key_sequencer_if #(parameter int MAX_DIGITS = 3);
    logic                    key_valid;
    logic [7:0]              key_code;
    logic                    key_ready;
    logic [4*MAX_DIGITS-1:0] num1;
    logic [2:0]              cnt1;
    logic [4*MAX_DIGITS-1:0] num2;
    logic [2:0]              cnt2;
    logic [7:0]              sym;
    logic                    start;
    logic                    done;
    logic [11:0]             result;
    logic [11:0]             disp;
    logic                    err;
    logic                    busy;
    modport master (
        output key_valid, key_code, done, result,
        input  key_ready, num1, cnt1, num2, cnt2, sym, start, disp, err, busy
    );
    modport slave (
        input  key_valid, key_code, done, result,
        output key_ready, num1, cnt1, num2, cnt2, sym, start, disp, err, busy
    );
endinterface

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: keypad front end building BCD operands, launching the datapath and driving the display.
// Optional macro CALC_CHAIN_EN: an operator in SHOW chains the result in as operand A.
module calc_key_sequencer #(
    parameter int MAX_DIGITS  = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                 clk,
    input logic                 rst,
    calc_key_sequencer_if.slave bus
);
    localparam int W = 4 * MAX_DIGITS;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [2:0] MAXC = 3'(MAX_DIGITS);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
`ifdef CALC_CHAIN_EN
    localparam logic [2:0] CHAINC = (MAX_DIGITS < 3) ? 3'(MAX_DIGITS) : 3'd3;
`endif
    typedef enum logic [2:0] {IDLE, OPA, OPB, EXEC, WAIT, SHOW, ERR} state_t;
    state_t        r_state, w_state_n;
    logic [W-1:0]  r_num1, r_num2, w_num1_n, w_num2_n;
    logic [2:0]    r_cnt1, r_cnt2, w_cnt1_n, w_cnt2_n;
    logic [7:0]    r_sym, w_sym_n;
    logic [11:0]   r_disp, w_disp_n;
    logic [TW-1:0] r_tmo, w_tmo_n;
    logic          r_start, r_err, r_busy;
    logic          w_ready, w_acc, w_dig, w_op, w_eq, w_clr;
    logic [W-1:0]  w_d, w_app1, w_app2;
    assign w_ready = !(r_state == EXEC || r_state == WAIT);
    assign w_acc   = bus.key_valid && w_ready;
    assign w_dig   = w_acc && bus.key_code >= 8'h30 && bus.key_code <= 8'h39;
    assign w_op    = w_acc && bus.key_code >= 8'h61 && bus.key_code <= 8'h64;
    assign w_eq    = w_acc && bus.key_code == 8'h65;
    assign w_clr   = w_acc && bus.key_code == 8'h66;
    assign w_d     = W'(bus.key_code[3:0]);
    assign w_app1  = W'({r_num1, 4'h0}) | w_d;
    assign w_app2  = W'({r_num2, 4'h0}) | w_d;
    always_comb begin
        w_state_n = r_state;
        w_num1_n  = r_num1;
        w_num2_n  = r_num2;
        w_cnt1_n  = r_cnt1;
        w_cnt2_n  = r_cnt2;
        w_sym_n   = r_sym;
        w_tmo_n   = r_tmo;
        if (w_clr) begin
            w_state_n = IDLE;
            w_num1_n  = '0;
            w_num2_n  = '0;
            w_cnt1_n  = '0;
            w_cnt2_n  = '0;
            w_sym_n   = '0;
            w_tmo_n   = '0;
        end else begin
            case (r_state)
                IDLE: if (w_dig) begin
                    w_num1_n  = w_d;
                    w_cnt1_n  = 3'd1;
                    w_state_n = OPA;
                end
                OPA: begin
                    if (w_dig && r_cnt1 < MAXC) begin
                        w_num1_n = w_app1;
                        w_cnt1_n = r_cnt1 + 3'd1;
                    end
                    if (w_op) begin
                        w_sym_n   = bus.key_code;
                        w_num2_n  = '0;
                        w_cnt2_n  = '0;
                        w_state_n = OPB;
                    end
                end
                OPB: begin
                    if (w_dig && r_cnt2 < MAXC) begin
                        w_num2_n = w_app2;
                        w_cnt2_n = r_cnt2 + 3'd1;
                    end
                    if (w_op && r_cnt2 == 3'd0) w_sym_n = bus.key_code;
                    // divide by zero is caught here so the datapath never sees it
                    if (w_eq && r_cnt2 != 3'd0)
                        w_state_n = (r_sym == 8'h64 && r_num2 == '0) ? ERR : EXEC;
                end
                EXEC: begin
                    w_tmo_n   = '0;
                    w_state_n = WAIT;
                end
                WAIT: begin
                    if (bus.done) w_state_n = SHOW;
                    else if (r_tmo == TLAST) w_state_n = ERR;
                    else w_tmo_n = r_tmo + TW'(1);
                end
                SHOW: begin
                    if (w_dig) begin
                        w_num1_n  = w_d;
                        w_cnt1_n  = 3'd1;
                        w_num2_n  = '0;
                        w_cnt2_n  = '0;
                        w_sym_n   = '0;
                        w_state_n = OPA;
                    end
`ifdef CALC_CHAIN_EN
                    if (w_op) begin
                        w_num1_n  = W'(bus.result);
                        w_cnt1_n  = CHAINC;
                        w_sym_n   = bus.key_code;
                        w_num2_n  = '0;
                        w_cnt2_n  = '0;
                        w_state_n = OPB;
                    end
`endif
                end
                default: ;
            endcase
        end
    end
    // display follows the next-state values so the registered disp is current with the state
    assign w_disp_n = (w_state_n == ERR)  ? 12'hEEE :
                      (w_state_n == IDLE) ? 12'h000 :
                      (w_state_n == OPA)  ? 12'(w_num1_n) :
                      (w_state_n == OPB)  ? ((w_cnt2_n != 3'd0) ? 12'(w_num2_n) : 12'(w_num1_n)) :
                      (r_state == WAIT && bus.done) ? bus.result : r_disp;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_num1  <= '0;
            r_num2  <= '0;
            r_cnt1  <= '0;
            r_cnt2  <= '0;
            r_sym   <= '0;
            r_disp  <= '0;
            r_tmo   <= '0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_num1  <= w_num1_n;
            r_num2  <= w_num2_n;
            r_cnt1  <= w_cnt1_n;
            r_cnt2  <= w_cnt2_n;
            r_sym   <= w_sym_n;
            r_disp  <= w_disp_n;
            r_tmo   <= w_tmo_n;
            r_start <= w_state_n == EXEC;
            r_err   <= w_state_n == ERR;
            r_busy  <= w_state_n == EXEC || w_state_n == WAIT;
        end
    end
    assign bus.key_ready = w_ready;
    assign bus.num1      = r_num1;
    assign bus.num2      = r_num2;
    assign bus.cnt1      = r_cnt1;
    assign bus.cnt2      = r_cnt2;
    assign bus.sym       = r_sym;
    assign bus.disp      = r_disp;
    assign bus.start     = r_start;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer: key-vector table plus datapath model with operand scoreboard.
module tb_calc_key_sequencer;
    localparam int TMO = 1024;
    typedef struct packed {
        logic [11:0] n1;
        logic [2:0]  c1;
        logic [11:0] n2;
        logic [2:0]  c2;
        logic [7:0]  sym;
        logic [11:0] disp;
        logic        err;
        logic        rdy;
    } obs_t;
    typedef struct packed {
        logic [7:0] key;
        obs_t       e;
    } vec_t;
    typedef struct packed {
        logic [11:0] n1;
        logic [11:0] n2;
        logic [7:0]  sym;
    } op_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0, n_fail = 0, n_start = 0, dp_delay = 0, dp_cnt = 0;
    logic [11:0] dp_result = 12'h000;
    op_t exp_q[$];
    op_t obs_q[$];
    vec_t vt[$];
    calc_key_sequencer_if #(.MAX_DIGITS(3)) bus();
    calc_key_sequencer #(.MAX_DIGITS(3), .TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    // datapath model: records operands at each start, answers dp_delay cycles later (0 = never)
    initial begin
        bus.done = 1'b0;
        bus.result = 12'h000;
        forever begin
            @(negedge clk);
            bus.done = 1'b0;
            if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0) begin
                    bus.done = 1'b1;
                    bus.result = dp_result;
                end
            end
            if (bus.start) begin
                n_start++;
                obs_q.push_back({bus.num1, bus.num2, bus.sym});
                dp_cnt = dp_delay;
            end
        end
    end
    function automatic obs_t snap();
        return {bus.num1, bus.cnt1, bus.num2, bus.cnt2, bus.sym, bus.disp, bus.err, bus.key_ready};
    endfunction
    function automatic vec_t v(logic [7:0] k, logic [11:0] n1, logic [2:0] c1, logic [11:0] n2,
                               logic [2:0] c2, logic [7:0] s, logic [11:0] d, logic e);
        return {k, n1, c1, n2, c2, s, d, e, 1'b1};
    endfunction
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic press(logic [7:0] k);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask
    task automatic run(int lo, int hi);
        for (int i = lo; i < hi; i++) begin
            press(vt[i].key);
            chk($sformatf("vec%0d_key%h", i, vt[i].key), snap(), vt[i].e);
        end
    endtask
    task automatic sb_check(string nm);
        op_t o, e;
        n_chk++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed starts %0d expected launches %0d", nm, obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: operands got %h expected %h", nm, o, e);
            end
        end
    endtask
    task automatic wait_idle(string nm);
        int k = 0;
        while (bus.busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(nm, bus.busy, 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int a0, b0, c0, d0, d1, base;
        bus.key_valid = 1'b0;
        bus.key_code = 8'h00;
        a0 = vt.size();
        vt.push_back(v(8'h65, 12'h000, 0, 12'h000, 0, 8'h00, 12'h000, 0));
        vt.push_back(v(8'h61, 12'h000, 0, 12'h000, 0, 8'h00, 12'h000, 0));
        vt.push_back(v(8'h39, 12'h009, 1, 12'h000, 0, 8'h00, 12'h009, 0));
        vt.push_back(v(8'h38, 12'h098, 2, 12'h000, 0, 8'h00, 12'h098, 0));
        vt.push_back(v(8'h37, 12'h987, 3, 12'h000, 0, 8'h00, 12'h987, 0));
        vt.push_back(v(8'h36, 12'h987, 3, 12'h000, 0, 8'h00, 12'h987, 0));
        vt.push_back(v(8'h66, 12'h000, 0, 12'h000, 0, 8'h00, 12'h000, 0));
        b0 = vt.size();
        vt.push_back(v(8'h35, 12'h005, 1, 12'h000, 0, 8'h00, 12'h005, 0));
        vt.push_back(v(8'h64, 12'h005, 1, 12'h000, 0, 8'h64, 12'h005, 0));
        vt.push_back(v(8'h30, 12'h005, 1, 12'h000, 1, 8'h64, 12'h000, 0));
        vt.push_back(v(8'h65, 12'h005, 1, 12'h000, 1, 8'h64, 12'hEEE, 1));
        vt.push_back(v(8'h31, 12'h005, 1, 12'h000, 1, 8'h64, 12'hEEE, 1));
        vt.push_back(v(8'h66, 12'h000, 0, 12'h000, 0, 8'h00, 12'h000, 0));
        c0 = vt.size();
        vt.push_back(v(8'h34, 12'h004, 1, 12'h000, 0, 8'h00, 12'h004, 0));
        vt.push_back(v(8'h61, 12'h004, 1, 12'h000, 0, 8'h61, 12'h004, 0));
        vt.push_back(v(8'h63, 12'h004, 1, 12'h000, 0, 8'h63, 12'h004, 0));
        vt.push_back(v(8'h65, 12'h004, 1, 12'h000, 0, 8'h63, 12'h004, 0));
        vt.push_back(v(8'h32, 12'h004, 1, 12'h002, 1, 8'h63, 12'h002, 0));
        d0 = vt.size();
        vt.push_back(v(8'h66, 12'h000, 0, 12'h000, 0, 8'h00, 12'h000, 0));
        vt.push_back(v(8'h31, 12'h001, 1, 12'h000, 0, 8'h00, 12'h001, 0));
        vt.push_back(v(8'h32, 12'h012, 2, 12'h000, 0, 8'h00, 12'h012, 0));
        vt.push_back(v(8'h65, 12'h012, 2, 12'h000, 0, 8'h00, 12'h012, 0));
        vt.push_back(v(8'h61, 12'h012, 2, 12'h000, 0, 8'h61, 12'h012, 0));
        vt.push_back(v(8'h33, 12'h012, 2, 12'h003, 1, 8'h61, 12'h003, 0));
        d1 = vt.size();
        #3;
        chk("reset_state", snap(), v(8'h00, 12'h000, 0, 12'h000, 0, 8'h00, 12'h000, 0).e);
        chk("reset_ctl", {bus.start, bus.busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        run(a0, b0);
        run(b0, c0);
        chk("divzero_no_start", n_start, 0);
        run(c0, d0);
        exp_q.push_back({12'h004, 12'h002, 8'h63});
        dp_delay = 3;
        dp_result = 12'h008;
        press(8'h65);
        chk("c_exec", {bus.start, bus.busy, bus.key_ready}, 3'b110);
        press(8'h31);
        wait_idle("c_done");
        chk("c_show", snap(), v(8'h00, 12'h004, 1, 12'h002, 1, 8'h63, 12'h008, 0).e);
        sb_check("c_ops");
        chk("c_one_start", n_start, 1);
        run(d0, d1);
        exp_q.push_back({12'h012, 12'h003, 8'h61});
        dp_delay = 2;
        dp_result = 12'h015;
        press(8'h65);
        chk("d_start_next_cycle", bus.start, 1);
        wait_idle("d_done");
        chk("d_show", snap(), v(8'h00, 12'h012, 2, 12'h003, 1, 8'h61, 12'h015, 0).e);
        sb_check("d_ops");
        chk("d_one_start", n_start, 2);
`ifdef CALC_CHAIN_EN
        press(8'h63);
        chk("chain_op", snap(), v(8'h00, 12'h015, 3, 12'h000, 0, 8'h63, 12'h015, 0).e);
        press(8'h32);
        chk("chain_digit", snap(), v(8'h00, 12'h015, 3, 12'h002, 1, 8'h63, 12'h002, 0).e);
        exp_q.push_back({12'h015, 12'h002, 8'h63});
        dp_result = 12'h030;
        press(8'h65);
        wait_idle("chain_done");
        chk("chain_show", snap(), v(8'h00, 12'h015, 3, 12'h002, 1, 8'h63, 12'h030, 0).e);
        sb_check("chain_ops");
        chk("chain_second_start", n_start, 3);
`else
        press(8'h63);
        chk("chain_off_ignored", snap(), v(8'h00, 12'h012, 2, 12'h003, 1, 8'h61, 12'h015, 0).e);
`endif
        press(8'h37);
        chk("show_digit", snap(), v(8'h00, 12'h007, 1, 12'h000, 0, 8'h00, 12'h007, 0).e);
        press(8'h66);
        press(8'h31);
        press(8'h61);
        press(8'h32);
        exp_q.push_back({12'h001, 12'h002, 8'h61});
        dp_delay = 0;
        base = n_start;
        press(8'h65);
        repeat (TMO) @(negedge clk);
        chk("tmo_not_yet", {bus.err, bus.busy}, 2'b01);
        @(negedge clk);
        chk("tmo_err", {bus.err, bus.busy, bus.disp}, {1'b1, 1'b0, 12'hEEE});
        sb_check("tmo_ops");
        chk("tmo_one_start", n_start - base, 1);
        press(8'h66);
        chk("err_clear", snap(), v(8'h00, 12'h000, 0, 12'h000, 0, 8'h00, 12'h000, 0).e);
        press(8'h31);
        press(8'h61);
        press(8'h32);
        exp_q.push_back({12'h001, 12'h002, 8'h61});
        press(8'h65);
        repeat (5) @(negedge clk);
        chk("rst_pre_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_state", snap(), v(8'h00, 12'h000, 0, 12'h000, 0, 8'h00, 12'h000, 0).e);
        chk("rst_async_ctl", {bus.start, bus.busy, bus.err}, 0);
        @(negedge clk);
        rst = 1'b0;
        sb_check("rst_ops");
        press(8'h33);
        chk("post_rst_digit", snap(), v(8'h00, 12'h003, 1, 12'h000, 0, 8'h00, 12'h003, 0).e);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
